ahb_master_interface: RTL and testbench
=======================================

// Module: ahb_master_interface
// PURPOSE
//  AHB-Lite initiator: accepts local read/write commands (single or INCR burst) and drives the
//  AHB address/data pipeline toward the AHB-to-APB bridge slave interface. Handles wait states,
//  1KB boundary splits and ERROR responses. Used by test masters and the DMA front-end.
// PARAMETERS
//  ADDR_W     32  address width (Haddr, cmd_addr)
//  DATA_W     32  data width (Hwdata, Hrdata, wr_data, rd_data)
//  LEN_W      4   cmd_len width; beats = cmd_len+1 (1..16)
// PORTS
//  Hclk        in   1       clock, all logic on rising edge
//  Hresetn     in   1       asynchronous active-low reset
//  cmd_valid   in   1       command request
//  cmd_ready   out  1       command accepted when cmd_valid & cmd_ready
//  cmd_addr    in   ADDR_W  start address, word aligned ([1:0] ignored, forced 00)
//  cmd_write   in   1       1 = write, 0 = read
//  cmd_len     in   LEN_W   beats-1
//  wr_data     in   DATA_W  write data for the beat whose address phase is completing
//  wr_data_ack out  1       pulse: wr_data consumed this cycle; next beat's data due
//  rd_data     out  DATA_W  registered read data
//  rd_valid    out  1       one-cycle pulse per completed read beat
//  busy        out  1       high from accept until last data phase completes
//  err         out  1       one-cycle pulse when an ERROR response aborts the command
//  Hreadyin    in   1       bus HREADY (slave ready)
//  Hresp       in   2       00 OKAY, 01 ERROR
//  Hrdata      in   DATA_W  read data
//  Haddr       out  ADDR_W  address phase address
//  Htrans      out  2       00 IDLE, 10 NONSEQ, 11 SEQ (BUSY 01 never issued)
//  Hwrite      out  1       transfer direction
//  Hsize       out  3       constant 010 (word)
//  Hburst      out  3       000 SINGLE when cmd_len==0, else 001 INCR
//  Hwdata      out  DATA_W  write data, driven in data phase
// BEHAVIOUR
//  Reset: Htrans=00, Haddr/Hwdata/rd_data=0, Hwrite=0, Hburst=000, cmd_ready=0, busy/err/
//   rd_valid/wr_data_ack=0; state IDLE. cmd_ready=1 from first clock after reset release.
//  FSM: IDLE -> ADDR (on accept) -> ADDR while beats remain -> LAST -> IDLE; ERR on abort.
//   IDLE: cmd_ready=1, Htrans=00. Accept registers addr/write/len; next cycle Htrans=10.
//   ADDR: address phase of beat k. Advances only when Hreadyin=1; else Haddr/Htrans/Hwrite/
//    Hwdata held stable. On advance: write -> Hwdata<=wr_data, wr_data_ack=1; Haddr+=4;
//    Htrans for beat k+1 = 11 (SEQ), or 10 (NONSEQ) if Haddr crosses a 1KB boundary
//    (next Haddr[9:0]==0). After last beat's address advances -> LAST, Htrans=00.
//   LAST: data phase of final beat; on Hreadyin=1 -> IDLE, busy drops same edge.
//  Read beats: on each data phase with Hreadyin=1 & Hresp=00, rd_data<=Hrdata, rd_valid=1.
//  Latency: single transfer = accept edge, +1 address, +1 data (zero wait) = busy 2 cycles.
//  Error: data phase seeing Hreadyin=0 & Hresp=01 (first ERROR cycle) -> next Htrans=00,
//   pending beats cancelled -> ERR; on Hreadyin=1 (second cycle) err pulse, -> IDLE.
//   No rd_valid for the errored beat. cmd_ready reasserts in IDLE.
//  Commands arriving while busy wait (cmd_ready=0); no back-to-back overlap.
//  Haddr increments wrap modulo 2^ADDR_W; no overflow flag.
//  Async reset mid-burst: all outputs to reset values immediately; burst abandoned.
// STRUCTURE
//  ahb_pkg: HTRANS_IDLE/NONSEQ/SEQ, HBURST_SINGLE/INCR, HSIZE_WORD, HRESP_OKAY/ERROR,
//   state encoding localparams; shared with the bridge slave interface.
//  Sub-module ahb_addr_gen: registered address + beat counter, next-address, 1KB-cross flag.
// TESTING
//  1 write 0x8000_0010 data 0xDEADBEEF, Hreadyin=1 -> Htrans=10 Haddr=0x8000_0010 Hwrite=1;
//    next cycle Hwdata=0xDEADBEEF, Htrans=00; busy low after 2 cycles.
//  2 read len=3 at 0x8400_0000 -> Htrans 10,11,11,11; Haddr +4 each; Hburst=001;
//    4 rd_valid pulses carrying Hrdata 0x11,0x22,0x33,0x44.
//  3 write len=2, Hreadyin=0 for 2 cycles at beat 1 -> Haddr/Htrans/Hwdata stable;
//    wr_data_ack exactly 3 pulses total.
//  4 read len=3 at 0x8000_03F8 -> beat 2 Haddr=0x8000_0400 with Htrans=10, beat 3 Htrans=11.
//  5 read len=3, Hresp=01 on beat 1 data phase -> Htrans=00 next, err pulse, 1 rd_valid only,
//    cmd_ready=1 afterwards.
//  6 Hresetn low mid-burst -> Htrans=00, busy=0 without waiting for Hclk; clean new command.

Source files
------------

// File: rtl/ahb_master_interface_pkg.sv
// Shared AHB-Lite encodings and the initiator FSM state type.
// Used by the AHB master interface and its address generator.
package ahb_master_interface_pkg;

    // Transfer type encodings (BUSY is never issued by this initiator)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Burst and size encodings
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Slave response encodings
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Byte stride between consecutive word beats
    localparam int unsigned BEAT_BYTES   = 4;

    // Initiator state: idle, address phase of a beat, data phase of the
    // final beat, and the second cycle of a two-cycle ERROR response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_LAST = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Burst type for a command: single-beat commands are SINGLE, the rest INCR
    function automatic logic [2:0] hburst_for(input logic single_beat);
        return single_beat ? HBURST_SINGLE : HBURST_INCR;
    endfunction

endpackage

// File: rtl/ahb_master_interface_if.sv
// AHB-Lite bus bundle between the initiator and the bridge slave port.
// The master modport drives the address/control/write-data side.
interface ahb_master_interface_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] Haddr;
    logic [1:0]        Htrans;
    logic              Hwrite;
    logic [2:0]        Hsize;
    logic [2:0]        Hburst;
    logic [DATA_W-1:0] Hwdata;
    logic [DATA_W-1:0] Hrdata;
    logic              Hreadyin;
    logic [1:0]        Hresp;

    modport master (
        output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata,
        input  Hrdata, Hreadyin, Hresp
    );

    modport slave (
        input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata,
        output Hrdata, Hreadyin, Hresp
    );

endinterface

// File: rtl/ahb_master_interface_addr_gen.sv
// Address generator for the AHB initiator: holds the current beat address
// and the count of beats still to be issued, and flags when the next word
// address starts a new 1KB region (AHB bursts must not cross it).
module ahb_master_interface_addr_gen
    import ahb_master_interface_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [LEN_W-1:0]  i_load_len,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_beat,
    output logic              o_cross_1k
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_beats_left;
    logic [ADDR_W-1:0] w_next_addr;

    // Word increment wraps modulo 2^ADDR_W by plain truncation
    assign w_next_addr = r_addr + ADDR_W'(BEAT_BYTES);

    assign o_addr      = r_addr;
    assign o_last_beat = (r_beats_left == '0);
    assign o_cross_1k  = (w_next_addr[9:0] == 10'd0);

    // Load a new command, or step to the next beat when an address phase completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_beats_left <= '0;
        end else if (i_load) begin
            r_addr       <= i_load_addr & ~ADDR_W'(3);
            r_beats_left <= i_load_len;
        end else if (i_advance && !o_last_beat) begin
            r_addr       <= w_next_addr;
            r_beats_left <= r_beats_left - LEN_W'(1);
        end
    end

endmodule

// File: rtl/ahb_master_interface.sv
// AHB-Lite initiator: turns local single/INCR read and write commands into a
// pipelined AHB address/data sequence. Handles wait states, restarts bursts
// with NONSEQ at 1KB boundaries and aborts on a two-cycle ERROR response.
module ahb_master_interface
    import ahb_master_interface_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    ahb_master_interface_if.master bus
);

    state_e            r_state;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_err;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic [2:0]        r_hburst;
    logic [DATA_W-1:0] r_hwdata;
    logic              r_dphase;     // a data phase is outstanding on the bus
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_accept;
    logic              w_advance;
    logic              w_error_first;
    logic              w_rd_beat_done;
    logic              w_last_beat;
    logic              w_cross_1k;
    logic [ADDR_W-1:0] w_haddr;

    // Command handshake and pipeline events
    assign w_accept       = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready;
    assign w_advance      = (r_state == ST_ADDR) && bus.Hreadyin;
    assign w_error_first  = r_dphase && !bus.Hreadyin && (bus.Hresp == HRESP_ERROR);
    assign w_rd_beat_done = r_dphase && !r_hwrite && bus.Hreadyin
                            && (bus.Hresp == HRESP_OKAY);

    ahb_master_interface_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .i_clk       (Hclk),
        .i_rst_n     (Hresetn),
        .i_load      (w_accept),
        .i_load_addr (cmd_addr),
        .i_load_len  (cmd_len),
        .i_advance   (w_advance),
        .o_addr      (w_haddr),
        .o_last_beat (w_last_beat),
        .o_cross_1k  (w_cross_1k)
    );

    // Bus outputs
    assign bus.Haddr  = w_haddr;
    assign bus.Htrans = r_htrans;
    assign bus.Hwrite = r_hwrite;
    assign bus.Hsize  = HSIZE_WORD;
    assign bus.Hburst = r_hburst;
    assign bus.Hwdata = r_hwdata;

    // Local side outputs. The write-data acknowledge is combinational so the
    // data source can present the next beat on the very edge that consumes
    // the current one, sustaining zero-wait bursts.
    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign err         = r_err;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign wr_data_ack = w_advance && r_hwrite;

    // Transfer sequencing: command accept, beat advance, final data phase, error abort
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_htrans    <= HTRANS_IDLE;
            r_hwrite    <= 1'b0;
            r_hburst    <= HBURST_SINGLE;
            r_hwdata    <= '0;
            r_dphase    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_ADDR;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_htrans    <= HTRANS_NONSEQ;
                        r_hwrite    <= cmd_write;
                        r_hburst    <= hburst_for(cmd_len == '0);
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                ST_ADDR: begin
                    if (w_error_first) begin
                        // Cancel the beat being offered and all later ones
                        r_state  <= ST_ERR;
                        r_htrans <= HTRANS_IDLE;
                        r_dphase <= 1'b0;
                    end else if (bus.Hreadyin) begin
                        r_dphase <= 1'b1;
                        if (r_hwrite) begin
                            r_hwdata <= wr_data;
                        end
                        if (w_last_beat) begin
                            r_state  <= ST_LAST;
                            r_htrans <= HTRANS_IDLE;
                        end else begin
                            r_htrans <= w_cross_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
                        end
                    end
                end

                ST_LAST: begin
                    if (w_error_first) begin
                        r_state  <= ST_ERR;
                        r_dphase <= 1'b0;
                    end else if (bus.Hreadyin) begin
                        r_state     <= ST_IDLE;
                        r_dphase    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end

                ST_ERR: begin
                    // Second ERROR cycle: report the abort and release the command
                    if (bus.Hreadyin) begin
                        r_state     <= ST_IDLE;
                        r_err       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data capture: one rd_valid pulse per read beat completing with OKAY
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_beat_done;
            if (w_rd_beat_done) begin
                r_rd_data <= bus.Hrdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_interface.sv
// Self-checking bench for ahb_master_interface. The bench plays the AHB
// slave and predicts each command from first principles: beat i lives at
// base+4*i, is NONSEQ when first or at a 1KB start, data flows in beat order,
// and an ERROR on beat e leaves beats 0..e issued and beats 0..e-1 read.
module tb_ahb_master_interface;
    import ahb_master_interface_pkg::*;

    logic        Hclk    = 1'b0;
    logic        Hresetn = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [3:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_data_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] beat_data [16];

    ahb_master_interface_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_master_interface #(
        .ADDR_W (32),
        .DATA_W (32),
        .LEN_W  (4)
    ) dut (
        .Hclk        (Hclk),
        .Hresetn     (Hresetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_len     (cmd_len),
        .wr_data     (wr_data),
        .wr_data_ack (wr_data_ack),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .err         (err),
        .bus         (bus)
    );

    always #5 Hclk = ~Hclk;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) beat_data[i] = $urandom();
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic w, input logic [3:0] l,
                             output bit ok);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
            ok = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom();
        ok = 1'b1;
    endtask

    // Run one command as the slave; err_beat<0 means no error, stall_beat<0 no forced stall
    task automatic run_cmd(input string name, input logic [31:0] base, input logic w,
                           input int len, input int err_beat, input int wait_pct,
                           input int stall_beat, input int stall_n);
        logic [31:0] exp_addr [16];
        logic [1:0]  exp_trans [16];
        logic [2:0]  exp_burst;
        logic [1:0]  exp_ht;
        logic [9:0]  low;
        int a_idx, d_idx, w_idx, rd_idx, ack_cnt, err_cnt, cyc, err_stage, stall_left;
        int n_addr, n_rd;
        bit ok, hrdy;

        for (int i = 0; i < 16; i++) begin
            exp_addr[i]  = (base & ~32'd3) + 32'(4 * i);
            low          = exp_addr[i][9:0];
            exp_trans[i] = (i == 0 || low == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end
        exp_burst  = (len == 0) ? 3'b000 : 3'b001;
        n_addr     = (err_beat >= 0) ? err_beat + 1 : len + 1;
        n_rd       = w ? 0 : ((err_beat >= 0) ? err_beat : len + 1);
        a_idx = 0; d_idx = -1; w_idx = 0; rd_idx = 0; ack_cnt = 0; err_cnt = 0;
        cyc = 0; err_stage = 0; stall_left = stall_n;

        wr_data = beat_data[0];
        issue_cmd(base, w, 4'(len), ok);
        if (!ok) return;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end

        forever begin
            if (rd_valid === 1'b1) begin
                n_tests++;
                if (rd_idx >= n_rd) begin
                    n_fail++;
                    $display("FAIL %s rd_valid: unexpected pulse #%0d, want only %0d", name, rd_idx, n_rd);
                end else if (rd_data !== beat_data[rd_idx]) begin
                    n_fail++;
                    $display("FAIL %s rd_data[%0d]: got %h want %h", name, rd_idx, rd_data, beat_data[rd_idx]);
                end
                rd_idx++;
            end
            if (err === 1'b1) err_cnt++;
            if (busy !== 1'b1) break;
            cyc++;
            if (cyc > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s timeout: busy still %b after 300 cycles", name, busy);
                break;
            end

            exp_ht = (err_stage > 0 || a_idx > len) ? HTRANS_IDLE : exp_trans[a_idx];
            n_tests++;
            if (bus.Htrans !== exp_ht) begin
                n_fail++;
                $display("FAIL %s Htrans cyc%0d: got %b want %b", name, cyc, bus.Htrans, exp_ht);
            end
            n_tests++;
            if (cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cmd_ready_busy cyc%0d: got %b want 0", name, cyc, cmd_ready);
            end
            if (exp_ht != HTRANS_IDLE) begin
                n_tests++;
                if (bus.Haddr !== exp_addr[a_idx] || bus.Hwrite !== w
                    || bus.Hburst !== exp_burst || bus.Hsize !== 3'b010) begin
                    n_fail++;
                    $display("FAIL %s addr_phase beat%0d: got a=%h w=%b b=%b s=%b want a=%h w=%b b=%b s=010",
                             name, a_idx, bus.Haddr, bus.Hwrite, bus.Hburst, bus.Hsize,
                             exp_addr[a_idx], w, exp_burst);
                end
            end
            if (d_idx >= 0 && w) begin
                n_tests++;
                if (bus.Hwdata !== beat_data[d_idx]) begin
                    n_fail++;
                    $display("FAIL %s Hwdata beat%0d: got %h want %h", name, d_idx, bus.Hwdata, beat_data[d_idx]);
                end
            end

            // Slave response for this cycle
            if (d_idx >= 0 && d_idx == err_beat) begin
                hrdy = (err_stage == 1);
                bus.Hresp = HRESP_ERROR;
                err_stage++;
            end else if (d_idx >= 0 && d_idx == stall_beat && stall_left > 0) begin
                hrdy = 1'b0;
                bus.Hresp = HRESP_OKAY;
                stall_left--;
            end else if (d_idx >= 0 && int'($urandom_range(99)) < wait_pct) begin
                hrdy = 1'b0;
                bus.Hresp = HRESP_OKAY;
            end else begin
                hrdy = 1'b1;
                bus.Hresp = HRESP_OKAY;
            end
            bus.Hreadyin = hrdy;
            bus.Hrdata   = (d_idx >= 0) ? beat_data[d_idx] : $urandom();
            wr_data      = (w_idx < 16) ? beat_data[w_idx] : $urandom();

            @(negedge Hclk);
            if (wr_data_ack === 1'b1) begin
                ack_cnt++;
                w_idx++;
            end
            if (hrdy) begin
                d_idx = -1;
                if (exp_ht != HTRANS_IDLE) begin
                    d_idx = a_idx;
                    a_idx++;
                end
            end
            @(posedge Hclk);
            #1;
        end

        bus.Hreadyin = 1'b1;
        bus.Hresp    = HRESP_OKAY;

        n_tests++;
        if (rd_idx != n_rd) begin
            n_fail++;
            $display("FAIL %s rd_count: got %0d want %0d", name, rd_idx, n_rd);
        end
        n_tests++;
        if (ack_cnt != (w ? n_addr : 0)) begin
            n_fail++;
            $display("FAIL %s wr_ack_count: got %0d want %0d", name, ack_cnt, w ? n_addr : 0);
        end
        n_tests++;
        if (err_cnt != ((err_beat >= 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s err_count: got %0d want %0d", name, err_cnt, (err_beat >= 0) ? 1 : 0);
        end
        n_tests++;
        if (a_idx != n_addr) begin
            n_fail++;
            $display("FAIL %s beats_issued: got %0d want %0d", name, a_idx, n_addr);
        end
        if (err_beat < 0 && wait_pct == 0 && stall_n == 0) begin
            n_tests++;
            if (cyc != len + 2) begin
                n_fail++;
                $display("FAIL %s busy_cycles: got %0d want %0d", name, cyc, len + 2);
            end
        end
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: got ready=%b busy=%b want ready=1 busy=0", name, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        Hresetn = 1'b0;
        #12;
        n_tests++;
        if (bus.Htrans !== 2'b00 || bus.Haddr !== 32'd0 || bus.Hwdata !== 32'd0
            || bus.Hwrite !== 1'b0 || bus.Hburst !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_bus: got t=%b a=%h wd=%h w=%b b=%b want all zero",
                     bus.Htrans, bus.Haddr, bus.Hwdata, bus.Hwrite, bus.Hburst);
        end
        n_tests++;
        if (rd_data !== 32'd0 || cmd_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0
            || rd_valid !== 1'b0 || wr_data_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_local: got rd=%h rdy=%b busy=%b err=%b rv=%b ack=%b want all zero",
                     rd_data, cmd_ready, busy, err, rd_valid, wr_data_ack);
        end
        @(negedge Hclk);
        Hresetn = 1'b1;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_early: got %b want 0", cmd_ready);
        end
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_first_clock: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single_write();
        fill_random();
        beat_data[0] = 32'hDEAD_BEEF;
        run_cmd("single_write", 32'h8000_0010, 1'b1, 0, -1, 0, -1, 0);
    endtask

    task automatic test_read_burst();
        beat_data[0] = 32'h11;
        beat_data[1] = 32'h22;
        beat_data[2] = 32'h33;
        beat_data[3] = 32'h44;
        run_cmd("read_burst", 32'h8400_0000, 1'b0, 3, -1, 0, -1, 0);
    endtask

    task automatic test_write_wait();
        fill_random();
        run_cmd("write_wait", 32'h8000_0100, 1'b1, 2, -1, 0, 1, 2);
    endtask

    task automatic test_1k_cross();
        fill_random();
        run_cmd("cross_1k", 32'h8000_03F8, 1'b0, 3, -1, 0, -1, 0);
        fill_random();
        run_cmd("addr_wrap", 32'hFFFF_FFF8, 1'b1, 3, -1, 0, -1, 0);
        fill_random();
        run_cmd("unaligned", 32'h8000_0023, 1'b0, 1, -1, 0, -1, 0);
    endtask

    task automatic test_error();
        fill_random();
        run_cmd("read_error", 32'h8000_0200, 1'b0, 3, 1, 0, -1, 0);
        fill_random();
        run_cmd("write_error_last", 32'h8000_0300, 1'b1, 2, 2, 0, -1, 0);
    endtask

    task automatic test_async_reset();
        bit ok;
        fill_random();
        issue_cmd(32'h8000_0800, 1'b0, 4'd15, ok);
        for (int i = 0; i < 4; i++) begin
            bus.Hreadyin = 1'b1;
            bus.Hresp    = HRESP_OKAY;
            bus.Hrdata   = $urandom();
            tick();
        end
        #2;
        Hresetn = 1'b0;
        #1;
        n_tests++;
        if (bus.Htrans !== 2'b00 || busy !== 1'b0 || bus.Haddr !== 32'd0
            || cmd_ready !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got t=%b busy=%b a=%h rdy=%b rv=%b want 00 0 0 0 0",
                     bus.Htrans, busy, bus.Haddr, cmd_ready, rd_valid);
        end
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick();
        fill_random();
        run_cmd("after_reset", 32'h8000_0C00, 1'b1, 1, -1, 0, -1, 0);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] base;
        int len, eb;
        logic w;
        for (int n = 0; n < 24; n++) begin
            fill_random();
            r    = $urandom();
            base = $urandom();
            if (r[1:0] == 2'b00) base = {base[31:10], 10'h3C0} + {26'd0, r[7:2]};
            len  = int'($urandom_range(15));
            w    = r[8];
            eb   = (r[12:10] == 3'b000) ? int'($urandom_range(len)) : -1;
            run_cmd("random", base, w, len, eb, 30, -1, 0);
        end
    endtask

    initial begin
        cmd_valid    = 1'b0;
        cmd_addr     = '0;
        cmd_write    = 1'b0;
        cmd_len      = '0;
        wr_data      = '0;
        bus.Hreadyin = 1'b1;
        bus.Hresp    = HRESP_OKAY;
        bus.Hrdata   = '0;

        test_reset();
        test_single_write();
        test_read_burst();
        test_write_wait();
        test_1k_cross();
        test_error();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
